xadc_drp_scan_sequencer: RTL
============================

# xadc_drp_scan_sequencer

Parametrised successor to the two-channel XADC DRP-to-AXIS adapter. On each XADC end-of-sequence it reads a configurable list of up to 16 DRP status registers and tags each result with its channel index. It merges all results onto one AXI-Stream with scan framing, decimation, overflow accounting and DRP timeout recovery. It sits between the XADC IP DRP port and the COBS encoder / USB FIFO path.

## Interface
- NUM_CHANNELS, 2, number of DRP addresses read per scan; legal range 1..16.
- CHANNEL_ADDRS, {XADC_ADDR_VAUX12, XADC_ADDR_VAUX4}, packed array [NUM_CHANNELS] of xadc_drp_addr_t; element 0 is read first.
- FIFO_DEPTH, 16, sample FIFO depth; power of 2, ≥ NUM_CHANNELS.
- DECIMATION, 1, process one EOS out of every DECIMATION; range 1..65535.
- xadc_dclk  in  1  DRP/system clock.
- xadc_reset  in  1  synchronous, active-high reset.
- enable  in  1  when low, new scans are not started; an in-progress scan completes.
- xadc_eos  in  1  end-of-sequence pulse from the XADC.
- xadc_daddr  out  7  DRP address, xadc_drp_addr_t.
- xadc_den  out  1  DRP enable, one-cycle pulse.
- xadc_drdy  in  1  DRP data ready.
- xadc_do  in  16  DRP read data.
- sample_stream  source  axis_interface.Source, DATA_WIDTH=16  tagged samples.
- overflow_count  out  16  saturating count of dropped or missed scans.
- busy  out  1  high while a scan is in progress.

## Operation
- FSM states and transitions:
  - IDLE → ISSUE when a scan is accepted.
  - ISSUE: assert xadc_den for 1 cycle with xadc_daddr = CHANNEL_ADDRS[idx], then go to WAIT.
  - WAIT → ISSUE on xadc_drdy, or → IDLE when idx is the last channel.
- Decimation counter increments on every xadc_eos seen in IDLE with enable high. A scan is triggered when the counter reaches DECIMATION−1; the counter then wraps to 0. With DECIMATION=1, every EOS triggers.
- Scan acceptance: a triggered scan starts only if FIFO free entries ≥ NUM_CHANNELS, so a whole scan always fits.
  - If space is short, the scan is dropped whole and overflow_count increments.
  - No partial scans ever enter the FIFO.
- xadc_eos in ISSUE or WAIT (scan still running) increments overflow_count and does not touch the decimation counter.
- overflow_count saturates at 16'hFFFF.
- Sample format:
  - tdata = {idx[3:0], xadc_do[15:4]}.
  - tid = idx.
  - tlast = 1 on the sample for idx = NUM_CHANNELS−1.
  - tuser = 1 only on timeout samples.
  - tkeep = '1; tdest = 0.
- DRP timeout: WAIT counts cycles. If XADC_DRP_TIMEOUT (255) elapses without xadc_drdy:
  - write sample {idx, 12'hFFF} with tuser = 1;
  - advance to the next channel exactly as if xadc_drdy had arrived.
- xadc_drdy is ignored outside WAIT.
- The FIFO drains independently of the FSM under AXIS backpressure.
- Reset values: xadc_den 0, xadc_daddr 0, busy 0, overflow_count 0, tvalid 0, FIFO empty, decimation counter 0, FSM IDLE.
- Reset mid-scan: the partial scan is abandoned, FIFO contents are discarded, and a late xadc_drdy after reset is ignored.

## Timing
- xadc_eos high at cycle N (accepted): xadc_den is high at cycle N+1, and busy is high from N+1.
- xadc_drdy at cycle M: sample is written to the FIFO at M+1, tvalid is observable at M+1 when the FIFO was empty, and the next xadc_den is at M+1.
- Last channel's xadc_drdy at cycle M: busy falls at M+1. A new scan may be accepted on an xadc_eos at M+1.
- AXIS: tdata/tid/tlast/tuser are held stable while tvalid && !tready. Transfer happens on tvalid && tready. Full throughput is 1 sample/cycle.
- FIFO full while the FSM writes cannot occur, because space is reserved at scan acceptance. Verification asserts this.
- Simultaneous FIFO write and read in the same cycle: occupancy is unchanged.

## Structure
- xadc_pkg holds:
  - xadc_drp_addr_t;
  - XADC_ADDR_VAUX0..15 (0x10..0x1F), e.g. XADC_ADDR_VAUX4 = 7'h14, XADC_ADDR_VAUX12 = 7'h1C;
  - XADC_DRP_TIMEOUT = 255;
  - the FSM state enum.
- Sub-module xadc_sample_fifo: synchronous FWFT FIFO.
  - Width 19 (tdata 16, tlast 1, tuser 1, plus one spare bit); tid is recovered from tdata[15:12].
  - Exposes a free-count output used for scan acceptance.

## Test plan
- NUM_CHANNELS=2, addrs {0x1C, 0x14}, DRP model returning 16'hABC0 / 16'h1230 with drdy 4 cycles after den, tready=1. One xadc_eos → two beats: tdata 16'h0ABC (tid 0, tlast 0), then 16'h1123 (tid 1, tlast 1); first xadc_den one cycle after EOS.
- DECIMATION=4, 12 EOS pulses spaced 100 cycles apart → exactly 3 scans emitted, at EOS #4, #8 and #12; overflow_count 0.
- FIFO_DEPTH=4, NUM_CHANNELS=2, tready=0, 3 scans → 2 scans stored (4 beats), overflow_count = 1. Raise tready → 4 beats drain intact with correct tlast.
- DRP model never asserts drdy for channel 1 → after 255 WAIT cycles, beat 16'h1FFF is emitted with tuser = 1 and tlast = 1; FSM returns to IDLE.
- xadc_eos mid-scan → overflow_count +1 and the scan output is unchanged. Assert xadc_reset while in WAIT, then a late xadc_drdy → no beat emitted, all outputs at reset values.
- enable low across 5 EOS pulses → no den, no beats, decimation counter frozen.

Source files
------------

// File: rtl/xadc_pkg.sv
`default_nettype none
// ============================================================================
//  xadc_pkg
//  Shared DRP address map, timeout, FSM encoding and FIFO word layout.
//  Revision: 1.0
// ============================================================================
package xadc_pkg;

   typedef logic [6:0] xadc_drp_addr_t;

   localparam xadc_drp_addr_t XADC_ADDR_VAUX0  = 7'h10;
   localparam xadc_drp_addr_t XADC_ADDR_VAUX1  = 7'h11;
   localparam xadc_drp_addr_t XADC_ADDR_VAUX2  = 7'h12;
   localparam xadc_drp_addr_t XADC_ADDR_VAUX3  = 7'h13;
   localparam xadc_drp_addr_t XADC_ADDR_VAUX4  = 7'h14;
   localparam xadc_drp_addr_t XADC_ADDR_VAUX5  = 7'h15;
   localparam xadc_drp_addr_t XADC_ADDR_VAUX6  = 7'h16;
   localparam xadc_drp_addr_t XADC_ADDR_VAUX7  = 7'h17;
   localparam xadc_drp_addr_t XADC_ADDR_VAUX8  = 7'h18;
   localparam xadc_drp_addr_t XADC_ADDR_VAUX9  = 7'h19;
   localparam xadc_drp_addr_t XADC_ADDR_VAUX10 = 7'h1A;
   localparam xadc_drp_addr_t XADC_ADDR_VAUX11 = 7'h1B;
   localparam xadc_drp_addr_t XADC_ADDR_VAUX12 = 7'h1C;
   localparam xadc_drp_addr_t XADC_ADDR_VAUX13 = 7'h1D;
   localparam xadc_drp_addr_t XADC_ADDR_VAUX14 = 7'h1E;
   localparam xadc_drp_addr_t XADC_ADDR_VAUX15 = 7'h1F;

   localparam int XADC_DRP_TIMEOUT = 255;

   typedef logic [1:0] fsm_state_t;
   localparam fsm_state_t ST_IDLE  = 2'd0;
   localparam fsm_state_t ST_ISSUE = 2'd1;
   localparam fsm_state_t ST_WAIT  = 2'd2;

   // tid is not stored: it is tdata[15:12]
   typedef struct packed {
      logic        spare;
      logic        tuser;
      logic        tlast;
      logic [15:0] tdata;
   } sample_t;

   localparam int XADC_SAMPLE_W = $bits(sample_t);

endpackage
`default_nettype wire

// File: rtl/xadc_sample_fifo.sv
`default_nettype none
// ============================================================================
//  xadc_sample_fifo
//  Synchronous first-word-fall-through FIFO with a free-entry count.
//  Revision: 1.0
// ============================================================================
module xadc_sample_fifo
   import xadc_pkg::*;
#(
   parameter int WIDTH = XADC_SAMPLE_W,
   parameter int DEPTH = 16
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_wr_en,
   input  logic [WIDTH-1:0]         i_wr_data,
   output logic                     o_full,
   input  logic                     i_rd_en,
   output logic [WIDTH-1:0]         o_rd_data,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_free
);

   localparam int c_AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_AW-1:0]  r_wr_ptr;
   logic [c_AW-1:0]  r_rd_ptr;
   logic [c_AW:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full    = (r_count == (c_AW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_free    = (c_AW+1)'(DEPTH) - r_count;
   assign o_rd_data = r_mem[r_rd_ptr];
   assign w_push    = i_wr_en && !o_full;
   assign w_pop     = i_rd_en && !o_empty;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/xadc_drp_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  xadc_drp_scan_sequencer
//  Reads a list of XADC DRP registers on each (decimated) EOS and streams
//  channel-tagged samples over AXI-Stream with scan framing and overflow count.
//  Revision: 1.0
// ============================================================================
module xadc_drp_scan_sequencer
   import xadc_pkg::*;
#(
   parameter int                              NUM_CHANNELS  = 2,
   parameter xadc_drp_addr_t [0:NUM_CHANNELS-1] CHANNEL_ADDRS = {XADC_ADDR_VAUX12, XADC_ADDR_VAUX4},
   parameter int                              FIFO_DEPTH    = 16,
   parameter int                              DECIMATION    = 1
)(
   input  logic        xadc_dclk,
   input  logic        xadc_reset,
   input  logic        enable,
   input  logic        xadc_eos,
   output logic [6:0]  xadc_daddr,
   output logic        xadc_den,
   input  logic        xadc_drdy,
   input  logic [15:0] xadc_do,
   output logic        sample_stream_tvalid,
   input  logic        sample_stream_tready,
   output logic [15:0] sample_stream_tdata,
   output logic [3:0]  sample_stream_tid,
   output logic        sample_stream_tlast,
   output logic        sample_stream_tuser,
   output logic [1:0]  sample_stream_tkeep,
   output logic        sample_stream_tdest,
   output logic [15:0] overflow_count,
   output logic        busy
);

   localparam int                 c_CNT_W        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [3:0]         c_LAST_IDX     = 4'(NUM_CHANNELS - 1);
   localparam logic [15:0]        c_DEC_LAST     = 16'(DECIMATION - 1);
   localparam logic [7:0]         c_WAIT_LAST    = 8'(XADC_DRP_TIMEOUT - 1);
   localparam logic [c_CNT_W-1:0] c_SCAN_ENTRIES = c_CNT_W'(NUM_CHANNELS);

   fsm_state_t         r_state;
   logic [3:0]         r_idx;
   xadc_drp_addr_t     r_daddr;
   logic [7:0]         r_wait_cnt;
   logic [15:0]        r_dec_cnt;
   logic [15:0]        r_ovf_cnt;

   logic               w_eos_idle;
   logic               w_trigger;
   logic               w_accept;
   logic               w_drop;
   logic               w_eos_busy;
   logic               w_timeout;
   logic               w_chan_done;
   logic               w_last;
   logic [3:0]         w_next_idx;
   xadc_drp_addr_t     w_next_addr;
   sample_t            w_wr_sample;
   logic [c_CNT_W-1:0] w_fifo_free;
   logic [XADC_SAMPLE_W-1:0] w_rd_word;
   logic               w_fifo_empty;
   logic               w_fifo_full;
   logic               w_unused;

   assign w_eos_idle  = (r_state == ST_IDLE) && enable && xadc_eos;
   assign w_trigger   = w_eos_idle && (r_dec_cnt == c_DEC_LAST);
   // Space for the whole scan is reserved up front so no scan is ever partial
   assign w_accept    = w_trigger && (w_fifo_free >= c_SCAN_ENTRIES);
   assign w_drop      = w_trigger && !w_accept;
   assign w_eos_busy  = xadc_eos && (r_state != ST_IDLE);
   assign w_timeout   = (r_state == ST_WAIT) && !xadc_drdy && (r_wait_cnt == c_WAIT_LAST);
   assign w_chan_done = (r_state == ST_WAIT) && (xadc_drdy || w_timeout);
   assign w_last      = (r_idx == c_LAST_IDX);
   assign w_next_idx  = (r_state == ST_IDLE) ? 4'd0 : r_idx + 4'd1;

   always_comb begin
      w_next_addr = CHANNEL_ADDRS[0];
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (4'(i) == w_next_idx) begin
            w_next_addr = CHANNEL_ADDRS[i];
         end
      end
   end

   always_comb begin
      w_wr_sample.spare = 1'b0;
      w_wr_sample.tuser = w_timeout;
      w_wr_sample.tlast = w_last;
      w_wr_sample.tdata = w_timeout ? {r_idx, 12'hFFF} : {r_idx, xadc_do[15:4]};
   end

   always_ff @(posedge xadc_dclk) begin
      if (xadc_reset) begin
         r_state    <= ST_IDLE;
         r_idx      <= '0;
         r_daddr    <= '0;
         r_wait_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state <= ST_ISSUE;
                  r_idx   <= w_next_idx;
                  r_daddr <= w_next_addr;
               end
            end
            ST_ISSUE: begin
               r_state    <= ST_WAIT;
               r_wait_cnt <= '0;
            end
            ST_WAIT: begin
               if (w_chan_done) begin
                  if (w_last) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_state <= ST_ISSUE;
                     r_idx   <= w_next_idx;
                     r_daddr <= w_next_addr;
                  end
               end else begin
                  r_wait_cnt <= r_wait_cnt + 8'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge xadc_dclk) begin
      if (xadc_reset) begin
         r_dec_cnt <= '0;
         r_ovf_cnt <= '0;
      end else begin
         if (w_eos_idle) begin
            r_dec_cnt <= (r_dec_cnt == c_DEC_LAST) ? 16'd0 : r_dec_cnt + 16'd1;
         end
         if ((w_drop || w_eos_busy) && (r_ovf_cnt != 16'hFFFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 16'd1;
         end
      end
   end

   xadc_sample_fifo #(
      .WIDTH (XADC_SAMPLE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (xadc_dclk),
      .rst       (xadc_reset),
      .i_wr_en   (w_chan_done),
      .i_wr_data (w_wr_sample),
      .o_full    (w_fifo_full),
      .i_rd_en   (sample_stream_tready),
      .o_rd_data (w_rd_word),
      .o_empty   (w_fifo_empty),
      .o_free    (w_fifo_free)
   );

   assign xadc_den             = (r_state == ST_ISSUE);
   assign xadc_daddr           = r_daddr;
   assign busy                 = (r_state != ST_IDLE);
   assign overflow_count       = r_ovf_cnt;
   assign sample_stream_tvalid = !w_fifo_empty;
   assign sample_stream_tdata  = w_rd_word[15:0];
   assign sample_stream_tid    = w_rd_word[15:12];
   assign sample_stream_tlast  = w_rd_word[16];
   assign sample_stream_tuser  = w_rd_word[17];
   assign sample_stream_tkeep  = 2'b11;
   assign sample_stream_tdest  = 1'b0;

   assign w_unused = ^{xadc_do[3:0], w_rd_word[18], w_fifo_full};

endmodule
`default_nettype wire
